// File: rtl/fc_pkg.sv
// Shared constants and FSM state encoding for the fully-connected layer sequencer.
package fc_pkg;

  localparam int N_IN    = 1568;
  localparam int ADDR_W  = 11;
  localparam int MAC_LAT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fc_state_e;

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Feature handshake plus weight-ROM / MAC-array control bundle of the FC sequencer.
interface fc_layer_sequencer_if #(
  parameter int AW = fc_pkg::ADDR_W
);
  import fc_pkg::*;

  logic          feat_valid;
  logic          feat_ready;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic          acc_clr;
  logic          acc_en;

  modport master (
    input  feat_valid,
    output feat_ready, rom_en, rom_addr, acc_clr, acc_en
  );

  modport slave (
    output feat_valid,
    input  feat_ready, rom_en, rom_addr, acc_clr, acc_en
  );

endinterface

// File: rtl/fc_valid_delay.sv
// Shift register carrying the feature-handshake bit towards the MAC accumulate edge.
module fc_valid_delay #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic din,
  output logic dout,
  output logic any
);
  import fc_pkg::*;

  logic [DEPTH-1:0] tap_q;
  logic [DEPTH-1:0] tap_d;

  always_comb begin
    tap_d = flush ? '0 : DEPTH'({tap_q, din});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tap_q <= '0;
    else      tap_q <= tap_d;
  end

  assign dout = tap_q[DEPTH-1];
  assign any  = |tap_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// Sequences one FC pass: clear accumulators, stream N_IN features into ROM reads,
// delay accumulate-enable to meet ROM data, then flag the ten scores valid.
module fc_layer_sequencer #(
  parameter int N_IN    = fc_pkg::N_IN,
  parameter int ADDR_W  = fc_pkg::ADDR_W,
  parameter int MAC_LAT = fc_pkg::MAC_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  fc_layer_sequencer_if.master  bus,
  output logic                  busy,
  output logic                  done,
  output logic                  res_valid
);
  import fc_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

  fc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              busy_q, busy_d;
  logic              res_valid_q, res_valid_d;
  logic              hs;
  logic              flush;
  logic              pipe_any;
  logic              pipe_out;

  assign hs = (state_q == RUN) && bus.feat_valid;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    busy_d         = busy_q;
    res_valid_d    = res_valid_q;
    flush          = 1'b0;
    bus.feat_ready = 1'b0;
    bus.rom_en     = 1'b0;
    bus.acc_clr    = 1'b0;
    done           = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d     = CLEAR;
          busy_d      = 1'b1;
          res_valid_d = 1'b0;
        end
      end
      CLEAR: begin
        bus.acc_clr = 1'b1;
        count_d     = '0;
        state_d     = RUN;
      end
      RUN: begin
        bus.feat_ready = 1'b1;
        if (hs) begin
          bus.rom_en = 1'b1;
          // The last address is held rather than incremented so count never leaves 0..N_IN-1.
          if (count_q == LAST_ADDR) state_d = DRAIN;
          else                      count_d = count_q + 1'b1;
        end
      end
      DRAIN: begin
        if (!pipe_any) state_d = DONE;
      end
      DONE: begin
        done        = 1'b1;
        res_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) begin
      res_valid_d = 1'b0;
      if (state_q != IDLE) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        count_d = '0;
        flush   = 1'b1;
        done    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
    end
  end

  fc_valid_delay #(
    .DEPTH (MAC_LAT)
  ) u_valid_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .din   (hs),
    .dout  (pipe_out),
    .any   (pipe_any)
  );

  assign bus.rom_addr = count_q;
  assign bus.acc_en   = pipe_out;
  assign busy         = busy_q;
  assign res_valid    = res_valid_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer with a handshake scoreboard and a ten-lane MAC model.
module tb_fc_layer_sequencer;
  import fc_pkg::*;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, res_valid;

  fc_layer_sequencer_if bus();

  fc_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .bus       (bus.master),
    .busy      (busy),
    .done      (done),
    .res_valid (res_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc, exp_addr, acc_cnt, clr_cyc, first_hs, last_hs, first_acc, last_acc;
  int done_cyc, done_cnt, rv0, rv1, aborted;
  int acc_q[$];
  int feat_mem[N_IN];
  int gold[10];
  int acc_m[10];
  int feat_data = 0;
  int addr_p1, addr_p2, addr_p3, feat_p1, feat_p2, feat_p3;

  function automatic int wgt(input int j, input int i);
    return ((i * 7 + j * 13) % 31) - 15;
  endfunction

  // MAC array model: ROM read register followed by two pipeline registers.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_p1 <= 0; addr_p2 <= 0; addr_p3 <= 0;
      feat_p1 <= 0; feat_p2 <= 0; feat_p3 <= 0;
      for (int j = 0; j < 10; j++) acc_m[j] <= 0;
    end else begin
      addr_p1 <= int'(bus.rom_addr); addr_p2 <= addr_p1; addr_p3 <= addr_p2;
      feat_p1 <= feat_data;          feat_p2 <= feat_p1; feat_p3 <= feat_p2;
      for (int j = 0; j < 10; j++) begin
        if (bus.acc_clr)     acc_m[j] <= 0;
        else if (bus.acc_en) acc_m[j] <= acc_m[j] + wgt(j, addr_p3) * feat_p3;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    int e;
    if (cyc == 0) rv0 = int'(res_valid);
    if (cyc == 1) rv1 = int'(res_valid);
    if (bus.acc_clr) clr_cyc = cyc;
    if (bus.feat_valid && bus.feat_ready) begin
      chk("rom_en_on_hs", int'(bus.rom_en), 1);
      chk("rom_addr", int'(bus.rom_addr), exp_addr);
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      acc_q.push_back(cyc + MAC_LAT);
      exp_addr++;
    end else begin
      chk("rom_en_no_hs", int'(bus.rom_en), 0);
    end
    if (bus.acc_en) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      e = (acc_q.size() > 0) ? acc_q.pop_front() : -1;
      chk("acc_en_cycle", cyc, e);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_sb();
    cyc = 0; exp_addr = 0; acc_cnt = 0; done_cnt = 0;
    clr_cyc = -1; first_hs = -1; last_hs = -1; first_acc = -1; last_acc = -1;
    done_cyc = -1; rv0 = -1; rv1 = -1;
    acc_q.delete();
  endtask

  task automatic run_pass(input int stall_pct, input int restart_at, input int abort_at);
    bit restarted;
    restarted = 0;
    aborted   = 0;
    clear_sb();
    for (int k = 0; k < 6000; k++) begin
      start = (k == 0);
      abort = 1'b0;
      bus.feat_valid = ($urandom_range(0, 99) >= stall_pct);
      if (restart_at >= 0 && !restarted && bus.feat_ready && exp_addr == restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      if (abort_at >= 0 && bus.feat_ready && exp_addr == abort_at) begin
        abort = 1'b1;
        bus.feat_valid = 1'b0;
      end
      feat_data = (exp_addr < N_IN) ? feat_mem[exp_addr] : 0;
      tick();
      if (abort) begin
        aborted = 1;
        break;
      end
      if (done_cnt > 0) break;
    end
    start = 1'b0;
    abort = 1'b0;
    bus.feat_valid = 1'b0;
  endtask

  task automatic check_full_pass(input string tag);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_acc_cnt"}, acc_cnt, N_IN);
    chk({tag, "_addr_cnt"}, exp_addr, N_IN);
    chk({tag, "_pending"}, acc_q.size(), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_res_valid"}, int'(res_valid), 1);
    for (int j = 0; j < 10; j++) chk($sformatf("%s_mac%0d", tag, j), acc_m[j], gold[j]);
  endtask

  task automatic check_nostall_timing(input string tag);
    chk({tag, "_clr_cyc"}, clr_cyc, 1);
    chk({tag, "_first_hs"}, first_hs, 2);
    chk({tag, "_last_hs"}, last_hs, N_IN + 1);
    chk({tag, "_first_acc"}, first_acc, 5);
    chk({tag, "_last_acc"}, last_acc, N_IN + 4);
    chk({tag, "_done_cyc"}, done_cyc, N_IN + 6);
  endtask

  initial begin
    bus.feat_valid = 1'b0;
    for (int i = 0; i < N_IN; i++) feat_mem[i] = int'($urandom_range(0, 255)) - 128;
    for (int j = 0; j < 10; j++) begin
      gold[j] = 0;
      for (int i = 0; i < N_IN; i++) gold[j] += wgt(j, i) * feat_mem[i];
    end

    // Reset state
    #12;
    chk("rst_feat_ready", int'(bus.feat_ready), 0);
    chk("rst_rom_en", int'(bus.rom_en), 0);
    chk("rst_rom_addr", int'(bus.rom_addr), 0);
    chk("rst_acc_clr", int'(bus.acc_clr), 0);
    chk("rst_acc_en", int'(bus.acc_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // No-stall pass
    run_pass(0, -1, -1);
    check_nostall_timing("t1");
    check_full_pass("t1");

    // Back-to-back start in the cycle after done
    run_pass(0, -1, -1);
    chk("t6_rv_before", rv0, 1);
    chk("t6_rv_clear", rv1, 0);
    check_nostall_timing("t6");
    check_full_pass("t6");

    // Random stalls
    for (int k = 0; k < 3; k++) tick();
    run_pass(50, -1, -1);
    check_full_pass("t2");

    // start while running is ignored
    run_pass(0, 700, -1);
    chk("t3_done_cyc", done_cyc, N_IN + 6);
    check_full_pass("t3");

    // Abort mid-pass
    run_pass(0, -1, 1000);
    chk("t4_aborted", aborted, 1);
    chk("t4_busy", int'(busy), 0);
    chk("t4_feat_ready", int'(bus.feat_ready), 0);
    chk("t4_res_valid", int'(res_valid), 0);
    chk("t4_acc_en", int'(bus.acc_en), 0);
    clear_sb();
    for (int k = 0; k < 6; k++) tick();
    chk("t4_no_done", done_cnt, 0);
    chk("t4_no_acc", acc_cnt, 0);
    run_pass(0, -1, -1);
    check_full_pass("t4_after");

    // Asynchronous reset during DRAIN
    clear_sb();
    for (int k = 0; k < 2000 && exp_addr < N_IN; k++) begin
      start = (k == 0);
      bus.feat_valid = 1'b1;
      feat_data = (exp_addr < N_IN) ? feat_mem[exp_addr] : 0;
      tick();
    end
    start = 1'b0;
    bus.feat_valid = 1'b0;
    chk("t5_reached_drain", exp_addr, N_IN);
    chk("t5_acc_en_before", int'(bus.acc_en), 1);
    #2 rst = 1'b0;
    #1;
    chk("t5_feat_ready", int'(bus.feat_ready), 0);
    chk("t5_rom_en", int'(bus.rom_en), 0);
    chk("t5_rom_addr", int'(bus.rom_addr), 0);
    chk("t5_acc_clr", int'(bus.acc_clr), 0);
    chk("t5_acc_en", int'(bus.acc_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_res_valid", int'(res_valid), 0);
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_idle_busy", int'(busy), 0);
    chk("t5_idle_ready", int'(bus.feat_ready), 0);
    run_pass(0, -1, -1);
    check_nostall_timing("t5_after");
    check_full_pass("t5_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
